// File: rtl/dp_operand_loader.sv
// dp_operand_loader: collects three operand words (a, b, c) from a valid/ready
// stream and presents them as a stable triple to a 32-bit datapath netlist.
// After c is accepted, the triple is held for HOLD_CYCLES cycles, with
// ops_valid high. result_strobe marks the last hold cycle, which is when the
// datapath's registered outputs are ready to be sampled.
//
// Optional feature macro: DP_LOADER_COUNT_EN adds the triple_count output, a
// wrapping count of completed triples that only Rst clears.
//
// Ports:
//   Clk            rising-edge clock
//   Rst            asynchronous active-high reset
//   flush          synchronous abort of any partial or held triple
//   in_data        operand word, presented in the order a, b, c
//   in_valid       in_data is valid
//   in_ready       loader accepts a word this cycle
//   a, b, c        operands to the datapath
//   ops_valid      a/b/c form a complete, stable triple
//   result_strobe  one-cycle pulse telling the consumer to sample x/z
//   triple_count   (DP_LOADER_COUNT_EN only) completed-triple counter
module dp_operand_loader #(
    parameter int unsigned DATAWIDTH   = 32,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 flush,
    input  logic [DATAWIDTH-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DATAWIDTH-1:0] a,
    output logic [DATAWIDTH-1:0] b,
    output logic [DATAWIDTH-1:0] c,
    output logic                 ops_valid,
    output logic                 result_strobe
`ifdef DP_LOADER_COUNT_EN
    ,
    output logic [15:0]          triple_count
`endif
);

    typedef enum logic [1:0] {StLoadA, StLoadB, StLoadC, StHold} state_e;

    // The counter is loaded with HOLD_CYCLES-1, so HOLD lasts HOLD_CYCLES cycles.
    localparam logic [7:0] HoldInit       = 8'(HOLD_CYCLES - 1);
    localparam logic       StrobeOnEntry  = (HOLD_CYCLES == 1);

    state_e                 state_q, state_d;
    logic [DATAWIDTH-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
    logic                   ops_valid_q, ops_valid_d;
    logic                   strobe_q, strobe_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   accept;
    logic                   hold_done;

    // A word is never taken on a flush cycle.
    assign accept    = in_valid & in_ready & ~flush;
    assign hold_done = (state_q == StHold) && (cnt_q == 8'd0);

    // State and datapath registers.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= StLoadA;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            ops_valid_q <= 1'b0;
            strobe_q    <= 1'b0;
            cnt_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            ops_valid_q <= ops_valid_d;
            strobe_q    <= strobe_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        ops_valid_d = ops_valid_q;
        strobe_d    = strobe_q;
        cnt_d       = cnt_q;
        if (flush) begin
            state_d     = StLoadA;
            a_d         = '0;
            b_d         = '0;
            c_d         = '0;
            ops_valid_d = 1'b0;
            strobe_d    = 1'b0;
            cnt_d       = 8'd0;
        end else begin
            unique case (state_q)
                StLoadA: begin
                    if (accept) begin
                        a_d     = in_data;
                        state_d = StLoadB;
                    end
                end
                StLoadB: begin
                    if (accept) begin
                        b_d     = in_data;
                        state_d = StLoadC;
                    end
                end
                StLoadC: begin
                    if (accept) begin
                        c_d         = in_data;
                        state_d     = StHold;
                        ops_valid_d = 1'b1;
                        cnt_d       = HoldInit;
                        strobe_d    = StrobeOnEntry;
                    end
                end
                StHold: begin
                    if (hold_done) begin
                        state_d     = StLoadA;
                        ops_valid_d = 1'b0;
                        strobe_d    = 1'b0;
                    end else begin
                        cnt_d    = cnt_q - 8'd1;
                        // Strobe is registered: raise it on entry to the last cycle.
                        strobe_d = (cnt_q == 8'd1);
                    end
                end
                default: state_d = StLoadA;
            endcase
        end
    end

    // Outputs.
    always_comb begin
        in_ready = 1'b0;
        unique case (state_q)
            StLoadA, StLoadB, StLoadC: in_ready = 1'b1;
            StHold:                    in_ready = 1'b0;
            default:                   in_ready = 1'b0;
        endcase
        a             = a_q;
        b             = b_q;
        c             = c_q;
        ops_valid     = ops_valid_q;
        result_strobe = strobe_q;
    end

`ifdef DP_LOADER_COUNT_EN
    logic [15:0] count_q;

    // Counts in step with result_strobe; flush aborts the triple uncounted.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            count_q <= 16'd0;
        end else if (hold_done && !flush) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign triple_count = count_q;
`endif

endmodule

// File: tb/tb_dp_operand_loader.sv
module tb_dp_operand_loader;

    logic        Clk = 1'b0;
    logic        Rst;
    // Default instance (HOLD_CYCLES=2).
    logic        flush;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b, c;
    logic        ops_valid, result_strobe;
    // Second instance with HOLD_CYCLES=1.
    logic        flush1;
    logic [31:0] in_data1;
    logic        in_valid1;
    logic        in_ready1;
    logic [31:0] a1, b1, c1;
    logic        ops_valid1, result_strobe1;
`ifdef DP_LOADER_COUNT_EN
    logic [15:0] triple_count, triple_count1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    dp_operand_loader #(.DATAWIDTH(32), .HOLD_CYCLES(2)) dut (
        .Clk(Clk), .Rst(Rst), .flush(flush), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .a(a), .b(b), .c(c), .ops_valid(ops_valid),
        .result_strobe(result_strobe)
`ifdef DP_LOADER_COUNT_EN
        , .triple_count(triple_count)
`endif
    );

    dp_operand_loader #(.DATAWIDTH(32), .HOLD_CYCLES(1)) dut1 (
        .Clk(Clk), .Rst(Rst), .flush(flush1), .in_data(in_data1), .in_valid(in_valid1),
        .in_ready(in_ready1), .a(a1), .b(b1), .c(c1), .ops_valid(ops_valid1),
        .result_strobe(result_strobe1)
`ifdef DP_LOADER_COUNT_EN
        , .triple_count(triple_count1)
`endif
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Checks the handshake/status outputs of the default instance.
    // Not a shared comparison helper: it is only used for status triples.
    task automatic test_reset();
        Rst = 1'b1; flush = 1'b0; in_data = '0; in_valid = 1'b0;
        flush1 = 1'b0; in_data1 = '0; in_valid1 = 1'b0;
        #12;
        checks++; if (a !== 32'd0 || b !== 32'd0 || c !== 32'd0) begin
            errors++; $display("FAIL reset_abc got %h %h %h want 0 0 0", a, b, c); end
        checks++; if (ops_valid !== 1'b0 || result_strobe !== 1'b0) begin
            errors++; $display("FAIL reset_flags got %b%b want 00", ops_valid, result_strobe); end
        checks++; if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready got %b want 1", in_ready); end
        @(posedge Clk); #1;
        Rst = 1'b0;
    endtask

    task automatic test_basic_load();
        in_valid = 1'b1; in_data = 32'd5; tick();
        checks++; if (a !== 32'd5 || in_ready !== 1'b1 || ops_valid !== 1'b0) begin
            errors++; $display("FAIL basic_a got a=%h rdy=%b ov=%b want 5 1 0", a, in_ready, ops_valid); end
        in_data = 32'd3; tick();
        checks++; if (b !== 32'd3 || ops_valid !== 1'b0) begin
            errors++; $display("FAIL basic_b got b=%h ov=%b want 3 0", b, ops_valid); end
        in_data = 32'd7; tick();
        in_valid = 1'b0;
        checks++; if (c !== 32'd7 || ops_valid !== 1'b1 || result_strobe !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL basic_hold1 got c=%h ov=%b rs=%b rdy=%b want 7 1 0 0",
                               c, ops_valid, result_strobe, in_ready); end
        tick();
        checks++; if (ops_valid !== 1'b1 || result_strobe !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL basic_hold2 got ov=%b rs=%b rdy=%b want 1 1 0",
                               ops_valid, result_strobe, in_ready); end
        tick();
        checks++; if (ops_valid !== 1'b0 || result_strobe !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL basic_done got ov=%b rs=%b rdy=%b want 0 0 1",
                               ops_valid, result_strobe, in_ready); end
        checks++; if (a !== 32'd5 || b !== 32'd3 || c !== 32'd7) begin
            errors++; $display("FAIL basic_keep got %h %h %h want 5 3 7", a, b, c); end
    endtask

    task automatic test_upstream_gaps();
        in_valid = 1'b1; in_data = 32'hFFFF_FFFF; tick();
        in_valid = 1'b0; in_data = 32'h1234_5678;
        repeat (3) tick();
        checks++; if (a !== 32'hFFFF_FFFF || b !== 32'd3 || in_ready !== 1'b1) begin
            errors++; $display("FAIL gaps_a got a=%h b=%h rdy=%b want ffffffff 3 1", a, b, in_ready); end
        in_valid = 1'b1; in_data = 32'd1; tick();
        in_valid = 1'b0; in_data = 32'hDEAD_BEEF;
        repeat (3) tick();
        checks++; if (b !== 32'd1 || c !== 32'd7 || ops_valid !== 1'b0) begin
            errors++; $display("FAIL gaps_b got b=%h c=%h ov=%b want 1 7 0", b, c, ops_valid); end
        in_valid = 1'b1; in_data = 32'd0; tick();
        in_valid = 1'b0;
        checks++; if (c !== 32'd0 || ops_valid !== 1'b1 || result_strobe !== 1'b0) begin
            errors++; $display("FAIL gaps_hold1 got c=%h ov=%b rs=%b want 0 1 0", c, ops_valid, result_strobe); end
        tick();
        checks++; if (ops_valid !== 1'b1 || result_strobe !== 1'b1) begin
            errors++; $display("FAIL gaps_hold2 got ov=%b rs=%b want 1 1", ops_valid, result_strobe); end
        tick();
        checks++; if (ops_valid !== 1'b0 || in_ready !== 1'b1 || a !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL gaps_done got ov=%b rdy=%b a=%h want 0 1 ffffffff",
                               ops_valid, in_ready, a); end
    endtask

    task automatic test_hold_ignore();
        in_valid = 1'b1;
        in_data = 32'd1; tick();
        in_data = 32'd2; tick();
        in_data = 32'd3; tick();
        in_data = 32'h0000_AAAA;
        tick();
        checks++; if (in_ready !== 1'b0 || a !== 32'd1 || b !== 32'd2 || c !== 32'd3) begin
            errors++; $display("FAIL hold_frozen got rdy=%b %h %h %h want 0 1 2 3", in_ready, a, b, c); end
        tick();
        checks++; if (a !== 32'd1 || in_ready !== 1'b1 || ops_valid !== 1'b0) begin
            errors++; $display("FAIL hold_exit got a=%h rdy=%b ov=%b want 1 1 0", a, in_ready, ops_valid); end
        tick();
        in_valid = 1'b0;
        checks++; if (a !== 32'h0000_AAAA) begin
            errors++; $display("FAIL hold_next_a got %h want 0000aaaa", a); end
    endtask

    task automatic test_flush();
        // Loader is in LOAD_B with a=0xAAAA.
        in_valid = 1'b1; in_data = 32'h0000_00BB; tick();
        flush = 1'b1; in_data = 32'h0000_00CC; tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (a !== 32'd0 || b !== 32'd0 || c !== 32'd0 || ops_valid !== 1'b0) begin
            errors++; $display("FAIL flush_clear got %h %h %h ov=%b want 0 0 0 0", a, b, c, ops_valid); end
        checks++; if (in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_ready got %b want 1", in_ready); end
        tick();
        checks++; if (a !== 32'd0 || ops_valid !== 1'b0) begin
            errors++; $display("FAIL flush_idle got a=%h ov=%b want 0 0", a, ops_valid); end
        in_valid = 1'b1;
        in_data = 32'd4; tick();
        in_data = 32'd5; tick();
        in_data = 32'd6; tick();
        in_valid = 1'b0;
        checks++; if (a !== 32'd4 || b !== 32'd5 || c !== 32'd6 || ops_valid !== 1'b1) begin
            errors++; $display("FAIL flush_fresh got %h %h %h ov=%b want 4 5 6 1", a, b, c, ops_valid); end
        repeat (2) tick();
    endtask

    task automatic test_hold1_count();
        for (int t = 0; t < 3; t++) begin
            in_valid1 = 1'b1;
            in_data1 = 32'(10 * t + 1); tick();
            in_data1 = 32'(10 * t + 2); tick();
            in_data1 = 32'(10 * t + 3); tick();
            in_valid1 = 1'b0;
            checks++; if (ops_valid1 !== 1'b1 || result_strobe1 !== 1'b1 || in_ready1 !== 1'b0
                          || c1 !== 32'(10 * t + 3)) begin
                errors++; $display("FAIL h1_pulse[%0d] got ov=%b rs=%b rdy=%b c=%h want 1 1 0 %h",
                                   t, ops_valid1, result_strobe1, in_ready1, c1, 32'(10 * t + 3)); end
            tick();
            checks++; if (ops_valid1 !== 1'b0 || result_strobe1 !== 1'b0 || in_ready1 !== 1'b1) begin
                errors++; $display("FAIL h1_end[%0d] got ov=%b rs=%b rdy=%b want 0 0 1",
                                   t, ops_valid1, result_strobe1, in_ready1); end
        end
`ifdef DP_LOADER_COUNT_EN
        checks++; if (triple_count1 !== 16'd3) begin
            errors++; $display("FAIL h1_count got %0d want 3", triple_count1); end
        checks++; if (triple_count !== 16'd4) begin
            errors++; $display("FAIL main_count got %0d want 4", triple_count); end
`endif
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1;
        in_data = 32'd9; tick();
        in_data = 32'd8; tick();
        in_data = 32'd7; tick();
        in_valid = 1'b0;
        checks++; if (ops_valid !== 1'b1) begin
            errors++; $display("FAIL areset_pre got ov=%b want 1", ops_valid); end
        #2 Rst = 1'b1;
        #1;
        checks++; if (ops_valid !== 1'b0 || a !== 32'd0 || b !== 32'd0 || c !== 32'd0) begin
            errors++; $display("FAIL areset_now got ov=%b %h %h %h want 0 0 0 0", ops_valid, a, b, c); end
        checks++; if (in_ready !== 1'b1) begin
            errors++; $display("FAIL areset_ready got %b want 1", in_ready); end
`ifdef DP_LOADER_COUNT_EN
        checks++; if (triple_count1 !== 16'd0) begin
            errors++; $display("FAIL areset_count got %0d want 0", triple_count1); end
`endif
        #1 Rst = 1'b0;
        tick();
        checks++; if (in_ready !== 1'b1 || ops_valid !== 1'b0) begin
            errors++; $display("FAIL areset_after got rdy=%b ov=%b want 1 0", in_ready, ops_valid); end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_upstream_gaps();
        test_hold_ignore();
        test_flush();
        test_hold1_count();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
